spram_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one jh_external_single_port_RAM between NUM_REQ requesters.

---
 rtl/spram_rr_arbiter.sv | 107 ++++++++++
 tb/tb_spram_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between NUM_REQ requesters.
// Reads are tracked through the RAM's fixed latency so each result returns only to its issuer.
module spram_rr_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int RAM_DEPTH  = 256,
    parameter  int NUM_REQ    = 4,
    parameter  int RAM_RD_LAT = 2,
    localparam int AW         = $clog2(RAM_DEPTH),
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*AW-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [AW-1:0]              ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_din,
    output logic                       ram_wr_en,
    input  logic [DATA_WIDTH-1:0]      ram_dout
);

    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         winner;
    logic                  found;
    logic                  rd_xfer;
    logic [RAM_RD_LAT-1:0] vld_q;
    logic [IW-1:0]         id_q [RAM_RD_LAT];

    // Two passes: requesters at or above the pointer first, then wrap to the low indices.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i >= int'(ptr_q))) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = found && (winner == IW'(i));
        end
    end

    // Grant is one-hot, so an OR-style mux over the granted lane is sufficient.
    always_comb begin
        ram_addr  = '0;
        ram_din   = '0;
        ram_wr_en = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                ram_addr  = req_addr[i*AW +: AW];
                ram_din   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                ram_wr_en = req_we[i];
            end
        end
        rd_xfer = found && !ram_wr_en;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            vld_q <= '0;
            for (int k = 0; k < RAM_RD_LAT; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            vld_q[0] <= rd_xfer;
            id_q[0]  <= winner;
            for (int k = 1; k < RAM_RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = vld_q[RAM_RD_LAT-1] && (id_q[RAM_RD_LAT-1] == IW'(i));
        end
    end

    assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed bench for spram_rr_arbiter with a behavioural two-stage RAM and a response scoreboard.
module tb_spram_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  rsp_rdata, ram_addr, ram_din, ram_dout;
    logic        ram_wr_en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] vld;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t q[$];

    logic [7:0] shadow [256];

    spram_rr_arbiter #(
        .DATA_WIDTH(8), .RAM_DEPTH(256), .NUM_REQ(4), .RAM_RD_LAT(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr_en(ram_wr_en),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered inputs, registered output, contents untouched by reset.
    logic [7:0] mem [256];
    logic [7:0] a_r, d_r;
    logic       we_r;
    always @(posedge clk) begin
        a_r      <= ram_addr;
        d_r      <= ram_din;
        we_r     <= ram_wr_en;
        if (we_r) mem[a_r] <= d_r;
        ram_dout <= mem[a_r];
    end

    always @(negedge clk) begin
        if (rsp_valid !== 4'b0000) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b rdata=%h, expected none (cycle %0d)",
                         rsp_valid, rsp_rdata, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rsp_valid !== e.vld || rsp_rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp: got valid=%b data=%h cycle=%0d, expected valid=%b data=%h cycle=%0d",
                             rsp_valid, rsp_rdata, cyc, e.vld, e.data, e.due);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] v, input logic [3:0] we, input logic [3:0] exp_rdy,
                         input logic [7:0] a, input logic [7:0] d, input string nm);
        logic hit, wsel;
        hit  = 1'b0;
        wsel = 1'b0;
        req_valid = v;
        req_we    = we;
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                hit  = 1'b1;
                wsel = we[i];
            end
            req_addr[i*8 +: 8]  = exp_rdy[i] ? a : 8'(8'hC0 + i);
            req_wdata[i*8 +: 8] = exp_rdy[i] ? d : 8'(8'hE0 + i);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s ready: got %b expected %b", nm, req_ready, exp_rdy);
        end
        checks++;
        if (ram_wr_en !== (hit && wsel) || (hit && ram_addr !== a)) begin
            errors++;
            $display("FAIL %s ram: got wr_en=%b addr=%h expected wr_en=%b addr=%h",
                     nm, ram_wr_en, ram_addr, hit && wsel, a);
        end
        if (hit && wsel) shadow[a] = d;
        else if (hit) q.push_back('{vld: exp_rdy, data: shadow[a], due: cyc + 2});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string nm);
        req_valid = '0;
        req_we    = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || ram_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL %s idle: got ready=%b wr_en=%b expected 0000/0", nm, req_ready, ram_wr_en);
            end
            checks++;
            if (ram_addr !== 8'h00 || ram_din !== 8'h00) begin
                errors++;
                $display("FAIL %s idle_bus: got addr=%h din=%h expected 00/00", nm, ram_addr, ram_din);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_cycles(input int n);
        rst       = 1'b1;
        req_valid = '0;
        q.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0000) begin
                errors++;
                $display("FAIL reset_rsp: got %b expected 0000", rsp_valid);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        @(posedge clk);
        #1;
        reset_cycles(2);

        // reads in flight, then reset flushes them
        issue(4'b0010, 4'b0000, 4'b0010, 8'h50, 8'h00, "rst_rd1");
        issue(4'b0100, 4'b0000, 4'b0100, 8'h51, 8'h00, "rst_rd2");
        reset_cycles(2);

        // all requesters valid: rotation 0,1,2,3,0,1,2,3 starting at 0 after reset
        for (int k = 0; k < 8; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            issue(4'b1111, 4'b1111, oh, 8'(8'h20 + k), 8'(8'h30 + k), "rotate");
        end

        issue(4'b0001, 4'b0001, 4'b0001, 8'h01, 8'h11, "fill1");
        issue(4'b0100, 4'b0100, 4'b0100, 8'h02, 8'h22, "fill2");
        issue(4'b1000, 4'b1000, 4'b1000, 8'h03, 8'h33, "fill3");

        // write then immediate read-back by req1
        issue(4'b0010, 4'b0010, 4'b0010, 8'h10, 8'hA5, "wr_a5");
        issue(4'b0010, 4'b0000, 4'b0010, 8'h10, 8'h00, "rd_a5");

        // back-to-back reads from different requesters
        issue(4'b0100, 4'b0000, 4'b0100, 8'h01, 8'h00, "b2b_r2");
        issue(4'b0001, 4'b0000, 4'b0001, 8'h02, 8'h00, "b2b_r0");
        issue(4'b1000, 4'b0000, 4'b1000, 8'h03, 8'h00, "b2b_r3");

        // req0 persistent, req3 arrives while pointer is 1
        issue(4'b0001, 4'b0001, 4'b0001, 8'h40, 8'h77, "gap_p0");
        issue(4'b1001, 4'b0001, 4'b1000, 8'h10, 8'h00, "gap_r3");
        issue(4'b0001, 4'b0001, 4'b0001, 8'h41, 8'h78, "gap_after");

        // idle gap keeps pointer at 1
        idle(5, "gap5");
        issue(4'b1111, 4'b1101, 4'b0010, 8'h02, 8'h00, "post_idle");
        issue(4'b1101, 4'b0000, 4'b0100, 8'h03, 8'h00, "post_idle2");

        idle(4, "drain");
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rsp_missing: got %0d outstanding expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
